// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: issues sequential word fetches and buffers in-order {pc, inst} pairs for decode.
// Latency: request accepted at cycle N, response at N+k, entry visible to decode at N+k+1.
// Backpressure: outstanding requests plus buffered entries never exceed FIFO_DEPTH, so the buffer cannot overflow.
module ifu_prefetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_i_halt,
  input  logic            ifu_i_redirect,
  input  logic [XLEN-1:0] ifu_i_pc_target,
  output logic            ifu_o_valid,
  input  logic            ifu_i_ready,
  output logic [XLEN-1:0] ifu_o_pc,
  output logic [XLEN-1:0] ifu_o_inst,
  output logic            ifu_o_ireq_valid,
  input  logic            ifu_i_ireq_ready,
  output logic [XLEN-1:0] ifu_o_iaddr,
  input  logic            ifu_i_irsp_valid,
  input  logic [XLEN-1:0] ifu_i_idata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] inst_mem [FIFO_DEPTH];

  logic [XLEN-1:0] target_pc;
  logic [CW:0]     in_use;
  logic            credit_ok;
  logic            req_fire;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            unused_tgt_lsbs;

  // Target is forced word aligned; the low bits carry no meaning.
  assign target_pc       = {ifu_i_pc_target[XLEN-1:2], 2'b00};
  assign unused_tgt_lsbs = ^ifu_i_pc_target[1:0];

  // A request may only go out if a buffer slot is guaranteed for its response.
  assign in_use           = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok        = in_use < (CW+1)'(FIFO_DEPTH);
  assign ifu_o_ireq_valid = !rst && !ifu_i_halt && !ifu_i_redirect && credit_ok;
  assign ifu_o_iaddr      = fetch_pc;
  assign req_fire         = ifu_o_ireq_valid && ifu_i_ireq_ready;

  // Redirect wins over any push/pop; stale responses are swallowed while drop_cnt is non-zero.
  assign fifo_empty  = (fifo_count == '0);
  assign ifu_o_valid = !fifo_empty;
  assign pop         = ifu_o_valid && ifu_i_ready && !ifu_i_redirect;
  assign push        = ifu_i_irsp_valid && (drop_cnt == '0) && !ifu_i_redirect;

  assign ifu_o_pc   = fifo_empty ? '0 : pc_mem[rd_ptr];
  assign ifu_o_inst = fifo_empty ? '0 : inst_mem[rd_ptr];

  // Track the next address to request and the PC owed to the next kept response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (ifu_i_redirect) begin
      fetch_pc <= target_pc;
      resp_pc  <= target_pc;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
      if (push)     resp_pc  <= resp_pc + PC_STEP;
    end
  end

  // Count in-flight requests and how many of them belong to a discarded stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(ifu_i_irsp_valid);
      if (ifu_i_redirect)
        drop_cnt <= outstanding - CW'(ifu_i_irsp_valid);
      else if (ifu_i_irsp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // Prefetch buffer pointers and occupancy; a redirect empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (ifu_i_redirect) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // Buffer storage; contents are only observable when the occupancy says so.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      inst_mem[wr_ptr] <= ifu_i_idata;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
module tb_ifu_prefetch;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halt = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] target = '0;
  logic        o_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        ireq_valid;
  logic        ireq_ready = 1'b0;
  logic [31:0] iaddr;
  logic        irsp_valid = 1'b0;
  logic [31:0] idata = '0;

  always #5 clk = ~clk;

  ifu_prefetch #(.XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .ifu_i_halt       (halt),
    .ifu_i_redirect   (redirect),
    .ifu_i_pc_target  (target),
    .ifu_o_valid      (o_valid),
    .ifu_i_ready      (dec_ready),
    .ifu_o_pc         (o_pc),
    .ifu_o_inst       (o_inst),
    .ifu_o_ireq_valid (ireq_valid),
    .ifu_i_ireq_ready (ireq_ready),
    .ifu_o_iaddr      (iaddr),
    .ifu_i_irsp_valid (irsp_valid),
    .ifu_i_idata      (idata)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] acc_log[$];
  logic [31:0] dec_log[$];
  logic [31:0] exp_req, exp_dec;
  int          checks = 0, failures = 0;
  int          cyc = 0, lat = 1, last_due = -1, base_cyc = 0, first_valid = -1;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Asynchronous reset applied between clock edges; memory model reset alongside.
  task automatic do_reset();
    #3 rst = 1'b1;
    irsp_valid = 1'b0; halt = 1'b0; redirect = 1'b0;
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_ireq_valid", 32'(ireq_valid), 0);
    chk("rst_iaddr", iaddr, RST_PC);
    chk("rst_pc", o_pc, 0);
    chk("rst_inst", o_inst, 0);
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); acc_log.delete(); dec_log.delete();
    exp_req = RST_PC; exp_dec = RST_PC;
    last_due = -1; base_cyc = cyc; first_valid = -1;
  endtask

  // One clock cycle: drive memory response, check outputs, update the reference model.
  task automatic tick();
    int d;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      irsp_valid = 1'b1;
      idata = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      irsp_valid = 1'b0;
      idata = $urandom;
    end
    #1;
    if (o_valid && first_valid < 0) first_valid = cyc - base_cyc;
    if (!o_valid) begin
      chk("empty_pc", o_pc, 0);
      chk("empty_inst", o_inst, 0);
    end
    if (redirect || halt) chk("req_blocked", 32'(ireq_valid), 0);
    if (ireq_valid && ireq_ready) begin
      chk("iaddr_seq", iaddr, exp_req);
      acc_log.push_back(iaddr);
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{addr: iaddr, due: d});
      exp_req = exp_req + 32'd4;
      chk("credit_cap", 32'(mq.size() <= DEPTH), 1);
    end
    if (!redirect && o_valid && dec_ready) begin
      chk("dec_pc", o_pc, exp_dec);
      chk("dec_inst", o_inst, mem_word(exp_dec));
      dec_log.push_back(o_pc);
      exp_dec = exp_dec + 32'd4;
    end
    if (redirect) begin
      exp_req = {target[31:2], 2'b00};
      exp_dec = {target[31:2], 2'b00};
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int n_before;

    // Reset, streaming with 1-cycle memory; start address wraps through zero
    do_reset();
    lat = 1; ireq_ready = 1'b1; dec_ready = 1'b1;
    repeat (12) tick();
    chk("t1_addr0", acc_log[0], 32'hFFFF_FFF8);
    chk("t1_addr1", acc_log[1], 32'hFFFF_FFFC);
    chk("t1_addr2", acc_log[2], 32'h0000_0000);
    chk("t1_addr3", acc_log[3], 32'h0000_0004);
    chk("t1_addr4", acc_log[4], 32'h0000_0008);
    chk("t1_dec0", dec_log[0], 32'hFFFF_FFF8);
    chk("t1_dec2", dec_log[2], 32'h0000_0000);
    chk("t1_first_valid_lat", 32'(first_valid), 2);

    // Decode stalled: exactly DEPTH requests accepted, then drain and resume
    do_reset();
    lat = 1; ireq_ready = 1'b1; dec_ready = 1'b0;
    repeat (8) tick();
    chk("t2_accepts", 32'(acc_log.size()), DEPTH);
    chk("t2_ireq_valid", 32'(ireq_valid), 0);
    chk("t2_head_valid", 32'(o_valid), 1);
    chk("t2_head_pc", o_pc, 32'hFFFF_FFF8);
    dec_ready = 1'b1;
    repeat (10) tick();
    chk("t2_dec3", dec_log[3], 32'h0000_0004);
    chk("t2_resume", acc_log[4], 32'h0000_0008);

    // Redirect in the cycle the first of three responses returns
    do_reset();
    lat = 3; ireq_ready = 1'b1; dec_ready = 1'b1;
    repeat (3) tick();
    ireq_ready = 1'b0;
    chk("t3_accepts", 32'(acc_log.size()), 3);
    redirect = 1'b1; target = 32'h0000_0103;
    tick();
    redirect = 1'b0; ireq_ready = 1'b1;
    repeat (12) tick();
    chk("t3_next_iaddr", acc_log[3], 32'h0000_0100);
    chk("t3_first_dec", dec_log[0], 32'h0000_0100);

    // Halt with two outstanding: responses land, no new requests
    do_reset();
    lat = 3; ireq_ready = 1'b1; dec_ready = 1'b1;
    repeat (2) tick();
    halt = 1'b1;
    repeat (8) tick();
    chk("t4_accepts", 32'(acc_log.size()), 2);
    chk("t4_delivered", 32'(dec_log.size()), 2);
    chk("t4_dec1", dec_log[1], 32'hFFFF_FFFC);
    halt = 1'b0;
    repeat (3) tick();
    chk("t4_resume", acc_log[2], 32'h0000_0000);

    // Back-to-back redirects: last target wins
    do_reset();
    lat = 3; ireq_ready = 1'b1; dec_ready = 1'b1;
    repeat (3) tick();
    redirect = 1'b1; target = 32'h0000_0200;
    tick();
    target = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    repeat (15) tick();
    chk("t5_next_iaddr", acc_log[3], 32'h0000_0300);
    chk("t5_first_dec", dec_log[0], 32'h0000_0300);

    // Randomized traffic with a reset in the middle of the stream
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) lat = $urandom_range(1, 4);
      if (i == 1500) do_reset();
      halt       = ($urandom_range(0, 9) == 0);
      redirect   = ($urandom_range(0, 19) == 0);
      target     = $urandom;
      dec_ready  = ($urandom_range(0, 3) != 0);
      ireq_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    halt = 1'b0; redirect = 1'b0; dec_ready = 1'b1; ireq_ready = 1'b1;
    n_before = dec_log.size();
    repeat (30) tick();
    chk("rand_progress", 32'(dec_log.size() > n_before), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
